// File: rtl/spi_master_protocol.sv
// SPI mode-0 initiator: each host request runs a config word (addr/rnw) then a data word, with SS gaps.
// Optional macro SPI_MASTER_LOOPBACK_EN adds a loopback input that captures the internal mosi instead of miso.
module spi_master_protocol #(
  parameter int SPI_DATA_W = 32,
  parameter int SPI_ADDR_W = 8,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYC    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rnw,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic [SPI_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [SPI_DATA_W-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  ss,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
`ifdef SPI_MASTER_LOOPBACK_EN
  ,
  input  logic                  loopback
`endif
);

  localparam int BIT_W = $clog2(SPI_DATA_W + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SPI_DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    CFG_SHIFT,
    GAP1,
    DATA_SHIFT,
    GAP2
  } state_e;

  state_e                  state_q, state_d;
  logic                    rnw_q, rnw_d;
  logic [SPI_DATA_W-1:0]   wdata_q, wdata_d;
  logic [SPI_DATA_W-1:0]   shreg_q, shreg_d;
  logic [SPI_DATA_W-1:0]   cap_q, cap_d;
  logic [SPI_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic                    sclk_q, sclk_d;

  logic                    shifting;
  logic                    accept;
  logic                    lb_en;
  logic                    cap_bit;
  logic [SPI_DATA_W-1:0]   cfg_word;
  logic [SPI_DATA_W-1:0]   data_word;
  logic [SPI_DATA_W-1:0]   rsp_word;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign lb_en = loopback;
`else
  assign lb_en = 1'b0;
`endif

  // Pads are decoded from state so an async reset returns them to idle levels immediately.
  assign shifting  = (state_q == CFG_SHIFT) || (state_q == DATA_SHIFT);
  assign ss        = ~shifting;
  assign sclk      = sclk_q;
  assign mosi      = shifting & shreg_q[SPI_DATA_W-1];
  assign busy      = (state_q != IDLE);
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign cap_bit   = lb_en ? mosi : miso;

  assign rsp_valid = (state_q == GAP2) && (gap_cnt_q == GAP_LAST);
  assign rsp_word  = rnw_q ? cap_q : '0;
  assign rsp_rdata = rsp_valid ? rsp_word : rsp_rdata_q;

  // Reads shift zeros in the data word, except loopback diagnostics which echo wdata.
  assign data_word = (rnw_q && !lb_en) ? '0 : wdata_q;

  always_comb begin
    cfg_word                 = '0;
    cfg_word[SPI_ADDR_W-1:0] = req_addr;
    cfg_word[SPI_ADDR_W]     = req_rnw;
  end

  always_comb begin
    state_d     = state_q;
    rnw_d       = rnw_q;
    wdata_d     = wdata_q;
    shreg_d     = shreg_q;
    cap_d       = cap_q;
    rsp_rdata_d = rsp_rdata_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sclk_d      = sclk_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rnw_d     = req_rnw;
          wdata_d   = req_wdata;
          shreg_d   = cfg_word;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          sclk_d    = 1'b0;
          state_d   = CFG_SHIFT;
        end
      end

      CFG_SHIFT, DATA_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            // Rising sclk: this edge is the slave's output sample point.
            if (state_q == DATA_SHIFT) begin
              cap_d = {cap_q[SPI_DATA_W-2:0], cap_bit};
            end
          end else if (bit_cnt_q == BIT_LAST) begin
            sclk_d    = 1'b0;
            gap_cnt_d = '0;
            state_d   = (state_q == CFG_SHIFT) ? GAP1 : GAP2;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = shreg_q << 1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      GAP1: begin
        if (gap_cnt_q == GAP_LAST) begin
          shreg_d   = data_word;
          cap_d     = '0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          sclk_d    = 1'b0;
          state_d   = DATA_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      GAP2: begin
        if (gap_cnt_q == GAP_LAST) begin
          rsp_rdata_d = rsp_word;
          state_d     = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnw_q       <= 1'b0;
      wdata_q     <= '0;
      shreg_q     <= '0;
      cap_q       <= '0;
      rsp_rdata_q <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      sclk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnw_q       <= rnw_d;
      wdata_q     <= wdata_d;
      shreg_q     <= shreg_d;
      cap_q       <= cap_d;
      rsp_rdata_q <= rsp_rdata_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sclk_q      <= sclk_d;
    end
  end

endmodule

// File: tb/tb_spi_master_protocol.sv
// Bench for spi_master_protocol: pad-level monitor plus slave miso driver, checked against transaction rules.
`timescale 1ns/1ps
module tb_spi_master_protocol;
  localparam int W    = 32;
  localparam int AW   = 8;
  localparam int CD   = 2;
  localparam int GC   = 4;
  localparam int CD_B = 1;
  localparam int GC_B = 1;
  localparam int LAT_A = 4 * CD * W + 2 * GC;
  localparam int LAT_B = 4 * CD_B * W + 2 * GC_B;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_rnw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          req_ready, rsp_valid, busy, ss, sclk, mosi;
  logic [W-1:0]  rsp_rdata;
  logic          miso = 1'b0;

  logic          req_valid_b = 1'b0, req_rnw_b = 1'b0;
  logic [AW-1:0] req_addr_b = '0;
  logic [W-1:0]  req_wdata_b = '0;
  logic          req_ready_b, rsp_valid_b, busy_b, ss_b, sclk_b, mosi_b;
  logic [W-1:0]  rsp_rdata_b;
  logic          miso_b = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic          loopback = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  spi_master_protocol #(.SPI_DATA_W(W), .SPI_ADDR_W(AW), .CLK_DIV(CD), .GAP_CYC(GC)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso)
`ifdef SPI_MASTER_LOOPBACK_EN
    , .loopback(loopback)
`endif
  );

  spi_master_protocol #(.SPI_DATA_W(W), .SPI_ADDR_W(AW), .CLK_DIV(CD_B), .GAP_CYC(GC_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_rnw(req_rnw_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .busy(busy_b), .ss(ss_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
`ifdef SPI_MASTER_LOOPBACK_EN
    , .loopback(1'b0)
`endif
  );

  // Reference: config word is addr plus rnw weighted at 2**AW.
  function automatic logic [W-1:0] exp_cfg(input logic rnw, input logic [AW-1:0] a);
    logic [W-1:0] v;
    v = W'(a);
    if (rnw) v = v + (W'(1) << AW);
    return v;
  endfunction

  // Pad monitor for dut_a: words seen on mosi, ss-low lengths, ss-high gaps; also acts as the slave.
  logic [W-1:0] slave_word = '0;
  logic [W-1:0] word_q[$];
  int           low_q[$];
  int           gap_q[$];
  int           rsp_cnt = 0, shape_err = 0, idle_err = 0;
  logic         prev_ss = 1'b1, prev_sclk = 1'b0;
  int           low_len = 0, hi_len = 0, rises = 0;
  logic [W-1:0] sh = '0;

  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (!ss) begin
      if (prev_ss) begin
        gap_q.push_back(hi_len);
        low_len = 0; rises = 0; sh = '0;
      end
      low_len++;
      if (sclk !== (((low_len - 1) / CD) % 2 == 1)) shape_err++;
      if (sclk && !prev_sclk) begin
        sh = {sh[W-2:0], mosi};
        rises++;
      end
      miso = (rises < W) ? slave_word[W-1-rises] : 1'b0;
    end else begin
      if (!prev_ss) begin
        word_q.push_back(sh);
        low_q.push_back(low_len);
        hi_len = 0;
      end
      hi_len++;
      if (sclk !== 1'b0 || mosi !== 1'b0) idle_err++;
      miso = 1'b0;
    end
    prev_ss   = ss;
    prev_sclk = sclk;
  end

  task automatic clear_mon();
    word_q.delete(); low_q.delete(); gap_q.delete();
    shape_err = 0; idle_err = 0;
  endtask

  task automatic run_txn(input logic rnw, input logic [AW-1:0] addr, input logic [W-1:0] wdata,
                         input logic [W-1:0] sw, output int lat, output logic [W-1:0] rdata);
    int guard;
    slave_word = sw;
    req_rnw = rnw; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 2000) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_rnw = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
    rdata = rsp_rdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_tests++; if ({ss, sclk, mosi} !== 3'b100) begin n_fail++; $display("FAIL rst_pads: got %b want 100", {ss, sclk, mosi}); end
    n_tests++; if ({rsp_valid, busy, req_ready} !== 3'b001) begin n_fail++; $display("FAIL rst_ctrl: got %b want 001", {rsp_valid, busy, req_ready}); end
    n_tests++; if (rsp_rdata !== '0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    n_tests++; if ({ss_b, sclk_b, busy_b, req_ready_b} !== 4'b1001) begin n_fail++; $display("FAIL rst_b: got %b want 1001", {ss_b, sclk_b, busy_b, req_ready_b}); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int lat; logic [W-1:0] rd;
    clear_mon();
    run_txn(1'b0, 8'h5A, 32'hDEADBEEF, $urandom, lat, rd);
    n_tests++; if (lat !== LAT_A) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT_A); end
    n_tests++; if (rd !== '0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", rd); end
    n_tests++;
    if (word_q.size() != 2 || gap_q.size() != 2) begin
      n_fail++; $display("FAIL wr_frames: got %0d words want 2", word_q.size());
    end else begin
      if (word_q[0] !== 32'h0000005A) begin n_fail++; $display("FAIL wr_cfg: got %h want 0000005a", word_q[0]); end
      n_tests++; if (word_q[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_data: got %h want deadbeef", word_q[1]); end
      n_tests++; if (low_q[0] != 2*CD*W || low_q[1] != 2*CD*W) begin n_fail++; $display("FAIL wr_ss_low: got %0d/%0d want %0d", low_q[0], low_q[1], 2*CD*W); end
      n_tests++; if (gap_q[1] != GC) begin n_fail++; $display("FAIL wr_gap1: got %0d want %0d", gap_q[1], GC); end
    end
    n_tests++; if (shape_err != 0 || idle_err != 0) begin n_fail++; $display("FAIL wr_shape: got %0d/%0d errors want 0", shape_err, idle_err); end
  endtask

  task automatic test_read();
    int lat; logic [W-1:0] rd;
    clear_mon();
    run_txn(1'b1, 8'h13, $urandom, 32'hCAFEF00D, lat, rd);
    n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_rdata: got %h want cafef00d", rd); end
    n_tests++; if (lat !== LAT_A) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT_A); end
    n_tests++;
    if (word_q.size() != 2) begin
      n_fail++; $display("FAIL rd_frames: got %0d words want 2", word_q.size());
    end else begin
      if (word_q[0] !== 32'h00000113) begin n_fail++; $display("FAIL rd_cfg: got %h want 00000113", word_q[0]); end
      n_tests++; if (word_q[1] !== '0) begin n_fail++; $display("FAIL rd_mosi_zero: got %h want 0", word_q[1]); end
    end
    n_tests++; if (rsp_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_hold: got %h want cafef00d", rsp_rdata); end
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] rd, wd, sw; logic [AW-1:0] a; logic r;
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      r = 1'($urandom_range(0, 1)); a = AW'($urandom); wd = $urandom; sw = $urandom;
      run_txn(r, a, wd, sw, lat, rd);
      n_tests++; if (rd !== (r ? sw : '0)) begin n_fail++; $display("FAIL rand%0d_rdata: got %h want %h", i, rd, r ? sw : '0); end
      n_tests++; if (lat !== LAT_A) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, LAT_A); end
      n_tests++;
      if (word_q.size() != 2) begin
        n_fail++; $display("FAIL rand%0d_frames: got %0d words want 2", i, word_q.size());
      end else if (word_q[0] !== exp_cfg(r, a) || word_q[1] !== (r ? '0 : wd)) begin
        n_fail++; $display("FAIL rand%0d_words: got %h %h want %h %h", i, word_q[0], word_q[1], exp_cfg(r, a), r ? '0 : wd);
      end
      n_tests++; if (shape_err != 0 || idle_err != 0) begin n_fail++; $display("FAIL rand%0d_shape: got %0d/%0d errors want 0", i, shape_err, idle_err); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, guard, bad; logic [W-1:0] w1, w2, sw; logic [AW-1:0] a1, a2; logic r1, r2;
    clear_mon();
    sw = $urandom; slave_word = sw;
    r1 = 1'($urandom_range(0, 1)); a1 = AW'($urandom); w1 = $urandom;
    r2 = 1'($urandom_range(0, 1)); a2 = AW'($urandom); w2 = $urandom;
    req_rnw = r1; req_addr = a1; req_wdata = w1; req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 2000) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_rnw = r2; req_addr = a2; req_wdata = w2;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
    n_tests++; if (lat !== LAT_A) begin n_fail++; $display("FAIL b2b_lat1: got %0d want %0d", lat, LAT_A); end
    n_tests++; if (rsp_rdata !== (r1 ? sw : '0)) begin n_fail++; $display("FAIL b2b_rdata1: got %h want %h", rsp_rdata, r1 ? sw : '0); end
    n_tests++; if (req_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp_cycle: got ready=%b busy=%b want 0 1", req_ready, busy); end
    @(posedge clk); #1;
    n_tests++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_cycle: got ready=%b busy=%b rsp=%b want 1 0 0", req_ready, busy, rsp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got busy=%b ready=%b want 1 0", busy, req_ready); end
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
    n_tests++; if (lat !== LAT_A) begin n_fail++; $display("FAIL b2b_lat2: got %0d want %0d", lat, LAT_A); end
    n_tests++; if (rsp_rdata !== (r2 ? sw : '0)) begin n_fail++; $display("FAIL b2b_rdata2: got %h want %h", rsp_rdata, r2 ? sw : '0); end
    @(posedge clk); #1;
    n_tests++;
    if (word_q.size() != 4 || gap_q.size() != 4) begin
      n_fail++; $display("FAIL b2b_frames: got %0d words want 4", word_q.size());
    end else begin
      if (word_q[0] !== exp_cfg(r1, a1) || word_q[2] !== exp_cfg(r2, a2)) begin
        n_fail++; $display("FAIL b2b_cfg: got %h %h want %h %h", word_q[0], word_q[2], exp_cfg(r1, a1), exp_cfg(r2, a2));
      end
      n_tests++;
      if (word_q[1] !== (r1 ? '0 : w1) || word_q[3] !== (r2 ? '0 : w2)) begin
        n_fail++; $display("FAIL b2b_data: got %h %h want %h %h", word_q[1], word_q[3], r1 ? '0 : w1, r2 ? '0 : w2);
      end
      bad = 0;
      for (int i = 1; i < 4; i++) if (gap_q[i] < GC) bad++;
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d short gaps want 0", bad); end
    end
  endtask

  task automatic test_reset_abort();
    int lat, cnt0, guard; logic [W-1:0] rd, wd;
    clear_mon();
    slave_word = $urandom;
    req_rnw = 1'b0; req_addr = 8'h5A; req_wdata = $urandom; req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 2000) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10 * 2 * CD) @(posedge clk);
    #2;
    n_tests++; if (ss !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre: got ss=%b busy=%b want 0 1", ss, busy); end
    cnt0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({ss, sclk, mosi, busy, rsp_valid, req_ready} !== 6'b100001) begin n_fail++; $display("FAIL abort_now: got %b want 100001", {ss, sclk, mosi, busy, rsp_valid, req_ready}); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT_A + 20) @(posedge clk);
    #1;
    n_tests++; if (rsp_cnt != cnt0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d pulses busy=%b want 0 0", rsp_cnt - cnt0, busy); end
    clear_mon();
    wd = $urandom;
    run_txn(1'b0, 8'h5A, wd, $urandom, lat, rd);
    n_tests++;
    if (word_q.size() != 2) begin
      n_fail++; $display("FAIL abort_frames: got %0d words want 2", word_q.size());
    end else if (word_q[0] !== 32'h0000005A || word_q[1] !== wd || low_q[0] != 2*CD*W) begin
      n_fail++; $display("FAIL abort_clean: got %h %h low %0d want 0000005a %h low %0d", word_q[0], word_q[1], low_q[0], wd, 2*CD*W);
    end
    n_tests++; if (lat !== LAT_A || rd !== '0) begin n_fail++; $display("FAIL abort_resume: got lat %0d rd %h want %0d 0", lat, rd, LAT_A); end
  endtask

  task automatic test_fast_read();
    int cyc, guard, nword, low, rb, shape;
    int lows[2];
    logic [W-1:0] wds[2];
    logic [W-1:0] sw, shb;
    logic [AW-1:0] a;
    logic pss, psclk;
    sw = $urandom; a = AW'($urandom);
    req_rnw_b = 1'b1; req_addr_b = a; req_wdata_b = $urandom; req_valid_b = 1'b1;
    guard = 0;
    while (req_ready_b !== 1'b1 && guard < 2000) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    cyc = 1; nword = 0; low = 0; rb = 0; shape = 0; shb = '0; pss = 1'b1; psclk = 1'b0;
    lows[0] = 0; lows[1] = 0; wds[0] = '0; wds[1] = '0;
    while (cyc < 1000) begin
      if (!ss_b) begin
        if (pss) begin low = 0; rb = 0; shb = '0; end
        low++;
        if (sclk_b !== (low % 2 == 0)) shape++;
        if (sclk_b && !psclk) begin shb = {shb[W-2:0], mosi_b}; rb++; end
        miso_b = (rb < W) ? sw[W-1-rb] : 1'b0;
      end else begin
        miso_b = 1'b0;
        if (!pss && nword < 2) begin lows[nword] = low; wds[nword] = shb; nword++; end
      end
      pss = ss_b; psclk = sclk_b;
      if (rsp_valid_b === 1'b1) break;
      @(posedge clk); #1; cyc++;
    end
    n_tests++; if (cyc != LAT_B) begin n_fail++; $display("FAIL fast_latency: got %0d want %0d", cyc, LAT_B); end
    n_tests++; if (rsp_rdata_b !== sw) begin n_fail++; $display("FAIL fast_rdata: got %h want %h", rsp_rdata_b, sw); end
    n_tests++; if (nword != 2 || lows[0] != 2*CD_B*W || lows[1] != 2*CD_B*W) begin n_fail++; $display("FAIL fast_ss_low: got %0d words %0d/%0d want 2 %0d", nword, lows[0], lows[1], 2*CD_B*W); end
    n_tests++; if (wds[0] !== exp_cfg(1'b1, a) || wds[1] !== '0) begin n_fail++; $display("FAIL fast_words: got %h %h want %h 0", wds[0], wds[1], exp_cfg(1'b1, a)); end
    n_tests++; if (shape != 0) begin n_fail++; $display("FAIL fast_sclk_period: got %0d errors want 0", shape); end
    @(posedge clk); #1;
  endtask

`ifdef SPI_MASTER_LOOPBACK_EN
  task automatic test_loopback();
    int lat; logic [W-1:0] rd;
    clear_mon();
    loopback = 1'b1;
    run_txn(1'b1, AW'($urandom), 32'h12345678, $urandom, lat, rd);
    loopback = 1'b0;
    n_tests++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL lb_rdata: got %h want 12345678", rd); end
    n_tests++; if (word_q.size() != 2 || word_q[1] !== 32'h12345678) begin n_fail++; $display("FAIL lb_mosi: got %0d words want data 12345678", word_q.size()); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_fast_read();
`ifdef SPI_MASTER_LOOPBACK_EN
    test_loopback();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
